reg_wb_arb: RTL and testbench
=============================

# reg_wb_arb

Writeback arbiter directly upstream of the GPR bank's single write port (`regIdRo`/`regValRo`). It merges two result sources into one registered write per cycle:
- single-cycle EX results;
- late memory-load results, buffered in a small FIFO.

It also exports a pending-write hazard flag so decode can stall on registers not yet committed. EX results normally win the port; a starvation counter guarantees the load FIFO drains.

## Interface
Parameters:
- `DEPTH`, 4, load FIFO entries; power of two, ≥2.
- `STARVE`, 4, consecutive EX wins tolerated while the FIFO is non-empty before the FIFO is forced onto the port.

Ports:
- `clock`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low; asserting low clears all state immediately.
- `exIdRo`  in  7  EX destination register id (CoreDefs `UREG_*` code).
- `exValRo`  in  32  EX result value.
- `exValid`  in  1  EX result present.
- `exReady`  out  1  EX result accepted this edge when `exValid && exReady`.
- `memIdRo`  in  7  load destination id.
- `memValRo`  in  32  load data.
- `memValid`  in  1  load result present.
- `memReady`  out  1  load result accepted this edge when `memValid && memReady`.
- `chkIdRs`, `chkIdRt`, `chkIdRn`  in  7 each  decode-stage register ids to hazard-check.
- `pendHit`  out  1  any check id matches a pending write.
- `regIdRo`  out  7  write id to GPR bank; `UREG_ZZR` = no write.
- `regValRo`  out  32  write value to GPR bank.
- `fifoCount`  out  log2(DEPTH)+1  current FIFO occupancy.

## Operation
- Output register (`regIdRo`/`regValRo`) is loaded every cycle with exactly one of: accepted EX result, FIFO head, bypassed load, or idle (`UREG_ZZR`, 0).
- Priority: forced FIFO grant > EX > FIFO head > bypassed load > idle.
- `exReady` = NOT forced-grant. EX is never backpressured otherwise.
- Forced grant = FIFO non-empty AND `starveCnt == STARVE`.
- `starveCnt` increments each cycle the FIFO is non-empty and an EX result takes the port. It clears on any FIFO dequeue, and while the FIFO is empty.
- FIFO dequeues the head when it wins the port; pointers wrap modulo DEPTH.
- `memReady` = `fifoCount < DEPTH`. At full, a same-cycle dequeue does not raise `memReady` that cycle.
- Simultaneous enqueue and dequeue: count unchanged.
- Results with id `UREG_ZZR` from either source are accepted and discarded: not enqueued, no output write, no hazard.
- `pendHit` is combinational. It is 1 when any non-`UREG_ZZR` check id equals the id of any valid FIFO entry, or of the output register when that holds a write.
- Two pending writes to the same id retire in acceptance order. An EX write to the same id as a queued load may retire first; decode uses `pendHit` to prevent this.

## Timing
- Reset values: `regIdRo`=`UREG_ZZR`, `regValRo`=0, `fifoCount`=0, `exReady`=1, `memReady`=1, `pendHit`=0 (for non-matching checks), `starveCnt`=0.
- EX accepted at edge N: visible on `regIdRo`/`regValRo` during cycle N+1; written into the GPR at edge N+1.
- Load via FIFO: enqueued edge N, earliest output at edge N+1, visible in cycle N+2.
- Worst-case wait for the FIFO head under continuous EX traffic: STARVE+1 cycles.
- Reset asserted mid-operation: FIFO contents, output register and counter are lost; outputs return to reset values asynchronously. On release, the first acceptance occurs at the next rising edge.

## Configuration
- `REGWB_LDBYPASS_EN` defined: if the FIFO is empty, no EX is accepted and `memValid` is high, the load goes straight to the output register. It is not enqueued, and latency is that of EX: visible at N+1.
- Undefined: every load passes through the FIFO (minimum 2-cycle latency). Behaviour is otherwise identical.

## Test plan
- Reset: hold `reset`=0 with random inputs → `regIdRo`=`UREG_ZZR`, `regValRo`=0, `fifoCount`=0; release, EX R3=0x1234 at edge 1 → `regIdRo`=R3, `regValRo`=0x1234 in cycle 2.
- Ordering: loads R1=0xA, R2=0xB on consecutive edges with no EX → R1 then R2 written in order; `fifoCount` returns to 0.
- Full: 5 loads with EX valid every cycle, DEPTH=4 → `memReady`=0 after the 4th load; 5th held until a dequeue.
- Starvation: FIFO holds R4=0x55, EX valid every cycle, STARVE=4 → 4 EX writes, then `exReady`=0 for one cycle and R4=0x55 written; the held EX result is written next.
- Hazard: load R5 queued, `chkIdRs`=R5 → `pendHit`=1 until the cycle after R5 leaves the output register; `chkIdRt`=`UREG_ZZR` → no hit.
- Bypass: with `REGWB_LDBYPASS_EN`, empty FIFO, load R6=0x77 at edge N → written in cycle N+1 and `fifoCount` stays 0; without the macro → written in cycle N+2.

Source files
------------

// File: rtl/reg_wb_arb.sv
// reg_wb_arb: writeback arbiter in front of the single GPR write port.
//
// Merges single-cycle EX results and late load results (buffered in a small
// FIFO) into one registered write per cycle. EX normally wins the port; a
// starvation counter forces the FIFO head through after STARVE consecutive
// EX wins while loads are waiting. pendHit flags decode-stage ids that still
// have a write in flight (queued in the FIFO or sitting in the output register).
//
// Optional feature: define REGWB_LDBYPASS_EN to send a load straight to the
// output register when the FIFO is empty and no EX write takes the port.
//
// Ports:
//   clock, reset (async, active-low)
//   exIdRo/exValRo/exValid/exReady      EX result handshake
//   memIdRo/memValRo/memValid/memReady  load result handshake
//   chkIdRs/chkIdRt/chkIdRn, pendHit    decode hazard check
//   regIdRo/regValRo                    registered GPR write (UREG_ZZR = none)
//   fifoCount                           load FIFO occupancy
module reg_wb_arb #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned STARVE   = 4,
  parameter logic [6:0]  UREG_ZZR = 7'h3F
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [6:0]                 exIdRo,
  input  logic [31:0]                exValRo,
  input  logic                       exValid,
  output logic                       exReady,
  input  logic [6:0]                 memIdRo,
  input  logic [31:0]                memValRo,
  input  logic                       memValid,
  output logic                       memReady,
  input  logic [6:0]                 chkIdRs,
  input  logic [6:0]                 chkIdRt,
  input  logic [6:0]                 chkIdRn,
  output logic                       pendHit,
  output logic [6:0]                 regIdRo,
  output logic [31:0]                regValRo,
  output logic [$clog2(DEPTH):0]     fifoCount
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned StW  = (STARVE > 0) ? $clog2(STARVE + 1) : 1;

  logic [6:0]      fifoId  [DEPTH];
  logic [31:0]     fifoVal [DEPTH];
  logic [PtrW-1:0] rdPtrQ, rdPtrD, wrPtrQ, wrPtrD;
  logic [CntW-1:0] countQ, countD;
  logic [StW-1:0]  starveQ, starveD;
  logic [6:0]      outIdD;
  logic [31:0]     outValD;

  logic fifoEmpty, forced, exWrite, memAcc, deq, enq, bypass;
  logic [PtrW-1:0] slot;

  function automatic logic idHit(input logic [6:0] id, input logic [6:0] rs,
                                 input logic [6:0] rt, input logic [6:0] rn,
                                 input logic [6:0] zzr);
    return ((rs != zzr) && (rs == id)) || ((rt != zzr) && (rt == id)) ||
           ((rn != zzr) && (rn == id));
  endfunction

  always_comb begin
    fifoEmpty = (countQ == '0);
    forced    = !fifoEmpty && (starveQ == StW'(STARVE));
    exReady   = !forced;
    memReady  = (countQ < CntW'(DEPTH));
    // A zero-register EX result is accepted but does not occupy the port.
    exWrite   = exValid && !forced && (exIdRo != UREG_ZZR);
    memAcc    = memValid && memReady;
    deq       = !fifoEmpty && (forced || !exWrite);
`ifdef REGWB_LDBYPASS_EN
    bypass    = fifoEmpty && !exWrite && memValid && (memIdRo != UREG_ZZR);
`else
    bypass    = 1'b0;
`endif
    enq       = memAcc && (memIdRo != UREG_ZZR) && !bypass;

    outIdD  = UREG_ZZR;
    outValD = '0;
    if (deq) begin
      outIdD  = fifoId[rdPtrQ];
      outValD = fifoVal[rdPtrQ];
    end else if (exWrite) begin
      outIdD  = exIdRo;
      outValD = exValRo;
    end else if (bypass) begin
      outIdD  = memIdRo;
      outValD = memValRo;
    end

    rdPtrD = deq ? rdPtrQ + 1'b1 : rdPtrQ;
    wrPtrD = enq ? wrPtrQ + 1'b1 : wrPtrQ;
    countD = countQ;
    if (enq && !deq) countD = countQ + 1'b1;
    else if (deq && !enq) countD = countQ - 1'b1;

    starveD = starveQ;
    if (deq || fifoEmpty) starveD = '0;
    else if (exWrite) starveD = starveQ + 1'b1;
  end

  // FIFO entries never hold UREG_ZZR, so only the output register needs the guard.
  always_comb begin
    pendHit = 1'b0;
    slot    = '0;
    if ((regIdRo != UREG_ZZR) && idHit(regIdRo, chkIdRs, chkIdRt, chkIdRn, UREG_ZZR)) begin
      pendHit = 1'b1;
    end
    for (int k = 0; k < DEPTH; k++) begin
      slot = rdPtrQ + PtrW'(k);
      if ((CntW'(k) < countQ) && idHit(fifoId[slot], chkIdRs, chkIdRt, chkIdRn, UREG_ZZR)) begin
        pendHit = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdPtrQ   <= '0;
      wrPtrQ   <= '0;
      countQ   <= '0;
      starveQ  <= '0;
      regIdRo  <= UREG_ZZR;
      regValRo <= '0;
    end else begin
      rdPtrQ   <= rdPtrD;
      wrPtrQ   <= wrPtrD;
      countQ   <= countD;
      starveQ  <= starveD;
      regIdRo  <= outIdD;
      regValRo <= outValD;
    end
  end

  // Storage needs no reset: occupancy alone decides which slots are live.
  always_ff @(posedge clock) begin
    if (enq) begin
      fifoId[wrPtrQ]  <= memIdRo;
      fifoVal[wrPtrQ] <= memValRo;
    end
  end

  assign fifoCount = countQ;

endmodule

// File: tb/tb_reg_wb_arb.sv
module tb_reg_wb_arb;
  localparam int DEPTH = 4;
  localparam int STARVE = 4;
  localparam logic [6:0] ZZR = 7'h3F;
`ifdef REGWB_LDBYPASS_EN
  localparam bit BypassEn = 1'b1;
`else
  localparam bit BypassEn = 1'b0;
`endif

  logic clock, reset;
  logic [6:0] exIdRo, memIdRo, chkIdRs, chkIdRt, chkIdRn, regIdRo;
  logic [31:0] exValRo, memValRo, regValRo;
  logic exValid, exReady, memValid, memReady, pendHit;
  logic [2:0] fifoCount;

  reg_wb_arb #(.DEPTH(DEPTH), .STARVE(STARVE), .UREG_ZZR(ZZR)) dut (
    .clock(clock), .reset(reset),
    .exIdRo(exIdRo), .exValRo(exValRo), .exValid(exValid), .exReady(exReady),
    .memIdRo(memIdRo), .memValRo(memValRo), .memValid(memValid), .memReady(memReady),
    .chkIdRs(chkIdRs), .chkIdRt(chkIdRt), .chkIdRn(chkIdRn), .pendHit(pendHit),
    .regIdRo(regIdRo), .regValRo(regValRo), .fifoCount(fifoCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {logic [6:0] id; logic [31:0] val;} ent_t;
  ent_t ldQ[$];
  int starve;
  logic [6:0] expId;
  logic [31:0] expVal;
  int nTests = 0;
  int nFail = 0;

  function automatic bit mForced();
    return (ldQ.size() > 0) && (starve == STARVE);
  endfunction

  function automatic bit mMemRdy();
    return ldQ.size() < DEPTH;
  endfunction

  function automatic bit mPend();
    logic [6:0] ids[$];
    ids.push_back(chkIdRs); ids.push_back(chkIdRt); ids.push_back(chkIdRn);
    foreach (ids[i]) begin
      if (ids[i] == ZZR) continue;
      if (expId == ids[i]) return 1'b1;
      foreach (ldQ[j]) if (ldQ[j].id == ids[i]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic modelReset();
    ldQ.delete();
    starve = 0;
    expId = ZZR;
    expVal = '0;
  endtask

  task automatic idleInputs();
    exValid = 0; exIdRo = ZZR; exValRo = 0;
    memValid = 0; memIdRo = ZZR; memValRo = 0;
    chkIdRs = ZZR; chkIdRt = ZZR; chkIdRn = ZZR;
  endtask

  // Advance model and DUT one clock using the inputs currently driven.
  task automatic tick();
    bit forced, exW, memRdy, byp;
    int pre;
    ent_t e;
    forced = mForced();
    memRdy = mMemRdy();
    exW = exValid && !forced && (exIdRo != ZZR);
    pre = ldQ.size();
    byp = 0;
    if (forced) begin
      e = ldQ.pop_front(); expId = e.id; expVal = e.val; starve = 0;
    end else if (exW) begin
      expId = exIdRo; expVal = exValRo;
      if (pre > 0) starve++;
    end else if (pre > 0) begin
      e = ldQ.pop_front(); expId = e.id; expVal = e.val; starve = 0;
    end else if (BypassEn && memValid && memIdRo != ZZR) begin
      expId = memIdRo; expVal = memValRo; byp = 1;
    end else begin
      expId = ZZR; expVal = 0;
    end
    if (pre == 0) starve = 0;
    if (memValid && memRdy && memIdRo != ZZR && !byp) begin
      e.id = memIdRo; e.val = memValRo;
      ldQ.push_back(e);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 0;
    modelReset();
    for (int i = 0; i < 4; i++) begin
      exValid = 1'($urandom); exIdRo = 7'($urandom); exValRo = $urandom;
      memValid = 1'($urandom); memIdRo = 7'($urandom); memValRo = $urandom;
      @(posedge clock); #1;
      nTests++;
      if (regIdRo !== ZZR || regValRo !== 0 || fifoCount !== 0 || exReady !== 1 || memReady !== 1)
      begin
        nFail++;
        $display("FAIL reset_hold: id=%h val=%h cnt=%0d exRdy=%b memRdy=%b, want %h 0 0 1 1",
                 regIdRo, regValRo, fifoCount, exReady, memReady, ZZR);
      end
    end
    idleInputs();
    reset = 1;
    exValid = 1; exIdRo = 7'd3; exValRo = 32'h1234;
    tick();
    exValid = 0;
    nTests++;
    if (regIdRo !== 7'd3 || regValRo !== 32'h1234) begin
      nFail++;
      $display("FAIL reset_first_ex: got %h/%h want 03/00001234", regIdRo, regValRo);
    end
    // Async reset mid-operation with a queued load.
    exValid = 1; exIdRo = 7'd9; exValRo = 32'h99;
    memValid = 1; memIdRo = 7'd2; memValRo = 32'h22;
    tick();
    idleInputs();
    nTests++;
    if (fifoCount !== 1 || regIdRo !== 7'd9) begin
      nFail++;
      $display("FAIL pre_async: cnt=%0d id=%h want 1/09", fifoCount, regIdRo);
    end
    #2 reset = 0;
    #1;
    modelReset();
    nTests++;
    if (regIdRo !== ZZR || regValRo !== 0 || fifoCount !== 0) begin
      nFail++;
      $display("FAIL async_reset: id=%h val=%h cnt=%0d want %h 0 0", regIdRo, regValRo,
               fifoCount, ZZR);
    end
    @(posedge clock); #1 reset = 1;
  endtask

  task automatic test_ordering();
    logic [6:0] seenId[$];
    logic [31:0] seenVal[$];
    idleInputs();
    memValid = 1; memIdRo = 7'd1; memValRo = 32'hA;
    tick();
    memIdRo = 7'd2; memValRo = 32'hB;
    tick();
    if (regIdRo != ZZR) begin seenId.push_back(regIdRo); seenVal.push_back(regValRo); end
    memValid = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      nTests++;
      if (regIdRo !== expId || regValRo !== expVal) begin
        nFail++;
        $display("FAIL order_model: got %h/%h want %h/%h", regIdRo, regValRo, expId, expVal);
      end
      if (regIdRo != ZZR) begin seenId.push_back(regIdRo); seenVal.push_back(regValRo); end
    end
    nTests++;
    if (seenId.size() != 2 || seenId[0] !== 7'd1 || seenVal[0] !== 32'hA ||
        seenId[1] !== 7'd2 || seenVal[1] !== 32'hB) begin
      nFail++;
      $display("FAIL order_seq: got %0d writes, want R1=A then R2=B", seenId.size());
    end
    nTests++;
    if (fifoCount !== 0) begin
      nFail++;
      $display("FAIL order_drain: cnt=%0d want 0", fifoCount);
    end
  endtask

  task automatic test_full();
    int ldAcc = 0;
    int exN = 0;
    bit sawFull = 0;
    idleInputs();
    for (int i = 0; i < 20 && ldAcc < 5; i++) begin
      exValid = 1; exIdRo = 7'(10 + exN % 8); exValRo = 32'(exN);
      memValid = 1; memIdRo = 7'(1 + ldAcc); memValRo = 32'(100 + ldAcc);
      if (!mForced()) exN++;
      if (mMemRdy()) ldAcc++;
      tick();
      nTests++;
      if (regIdRo !== expId || fifoCount !== 3'(ldQ.size()) || memReady !== mMemRdy()) begin
        nFail++;
        $display("FAIL full_model: id=%h cnt=%0d memRdy=%b want %h %0d %b", regIdRo,
                 fifoCount, memReady, expId, ldQ.size(), mMemRdy());
      end
      if (ldAcc == 4 && !sawFull) begin
        sawFull = 1;
        nTests++;
        if (memReady !== 0 || fifoCount !== 4) begin
          nFail++;
          $display("FAIL full_ready: memRdy=%b cnt=%0d want 0/4", memReady, fifoCount);
        end
      end
    end
    nTests++;
    if (ldAcc != 5) begin
      nFail++;
      $display("FAIL full_fifth: accepted %0d loads, want 5", ldAcc);
    end
    idleInputs();
    for (int i = 0; i < 10 && ldQ.size() > 0; i++) tick();
    nTests++;
    if (fifoCount !== 0) begin
      nFail++;
      $display("FAIL full_drain: cnt=%0d want 0", fifoCount);
    end
    tick();
  endtask

  task automatic test_starvation();
    logic [6:0] want[6] = '{7'd21, 7'd22, 7'd23, 7'd24, 7'd4, 7'd25};
    int exN = 21;
    idleInputs();
    exValid = 1; exIdRo = 7'd20; exValRo = 32'd20;
    memValid = 1; memIdRo = 7'd4; memValRo = 32'h55;
    tick();
    memValid = 0;
    for (int i = 0; i < 6; i++) begin
      exIdRo = 7'(exN); exValRo = 32'(exN);
      nTests++;
      if (exReady !== (i != 4)) begin
        nFail++;
        $display("FAIL starve_exready[%0d]: got %b want %b", i, exReady, (i != 4));
      end
      if (exReady) exN++;
      tick();
      nTests++;
      if (regIdRo !== want[i] || (i == 4 && regValRo !== 32'h55)) begin
        nFail++;
        $display("FAIL starve_seq[%0d]: got %h/%h want %h", i, regIdRo, regValRo, want[i]);
      end
    end
    idleInputs();
    tick();
  endtask

  task automatic test_hazard();
    idleInputs();
    chkIdRs = 7'd5; chkIdRt = ZZR; chkIdRn = 7'd0;
    exValid = 1; exIdRo = 7'd30; exValRo = 1;
    memValid = 1; memIdRo = 7'd5; memValRo = 32'h5;
    tick();
    exValid = 0; memValid = 0;
    nTests++;
    if (pendHit !== 1) begin
      nFail++;
      $display("FAIL hazard_queued: pendHit=%b want 1", pendHit);
    end
    chkIdRs = ZZR; #1;
    nTests++;
    if (pendHit !== 0) begin
      nFail++;
      $display("FAIL hazard_zzr: pendHit=%b want 0", pendHit);
    end
    chkIdRs = 7'd5;
    tick();
    nTests++;
    if (pendHit !== 1 || regIdRo !== 7'd5) begin
      nFail++;
      $display("FAIL hazard_outreg: pendHit=%b id=%h want 1/05", pendHit, regIdRo);
    end
    tick();
    nTests++;
    if (pendHit !== 0) begin
      nFail++;
      $display("FAIL hazard_retired: pendHit=%b want 0", pendHit);
    end
    idleInputs();
  endtask

  task automatic test_bypass();
    idleInputs();
    tick();
    memValid = 1; memIdRo = 7'd6; memValRo = 32'h77;
    tick();
    memValid = 0;
    nTests++;
    if (BypassEn ? (regIdRo !== 7'd6 || regValRo !== 32'h77 || fifoCount !== 0)
                 : (regIdRo !== ZZR || fifoCount !== 1)) begin
      nFail++;
      $display("FAIL bypass_n1: id=%h val=%h cnt=%0d (bypass=%0d)", regIdRo, regValRo,
               fifoCount, BypassEn);
    end
    tick();
    nTests++;
    if (BypassEn ? (regIdRo !== ZZR) : (regIdRo !== 7'd6 || regValRo !== 32'h77)) begin
      nFail++;
      $display("FAIL bypass_n2: id=%h val=%h (bypass=%0d)", regIdRo, regValRo, BypassEn);
    end
  endtask

  function automatic logic [6:0] rndId();
    return ($urandom_range(0, 7) == 0) ? ZZR : 7'($urandom_range(0, 6));
  endfunction

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      exValid = ($urandom_range(0, 3) != 0); exIdRo = rndId(); exValRo = $urandom;
      memValid = ($urandom_range(0, 1) != 0); memIdRo = rndId(); memValRo = $urandom;
      chkIdRs = rndId(); chkIdRt = rndId(); chkIdRn = rndId();
      #1;
      nTests++;
      if (exReady !== !mForced() || memReady !== mMemRdy() || pendHit !== mPend()) begin
        nFail++;
        $display("FAIL rand_comb[%0d]: exRdy=%b memRdy=%b hit=%b want %b %b %b", i, exReady,
                 memReady, pendHit, !mForced(), mMemRdy(), mPend());
      end
      tick();
      nTests++;
      if (regIdRo !== expId || regValRo !== expVal || fifoCount !== 3'(ldQ.size())) begin
        nFail++;
        $display("FAIL rand_state[%0d]: %h/%h cnt=%0d want %h/%h cnt=%0d", i, regIdRo,
                 regValRo, fifoCount, expId, expVal, ldQ.size());
      end
    end
    idleInputs();
  endtask

  initial begin
    idleInputs();
    reset = 0;
    modelReset();
    test_reset();
    test_ordering();
    test_full();
    test_starvation();
    test_hazard();
    test_bypass();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
